// File: rtl/zbb_count_seq.sv
// -----------------------------------------------------------------------------
// zbb_count_seq
//   Shared multi-cycle bit-count engine for the Zbb unit-count operations
//   CLZ, CTZ and CPOP. Two requesters are arbitrated round-robin. The accepted
//   operand is scanned CHUNK bits per cycle, and a single tagged result is
//   returned over a valid/ready response channel. Only one operation is in
//   flight at a time.
//
//   All three operations scan LSB-first. The CLZ operand is bit-reversed at
//   accept time, which turns its leading-zero count into a trailing-zero count.
//
// Parameters
//   XLEN   operand and result width
//   CHUNK  bits scanned per RUN cycle (XLEN must be a multiple of CHUNK)
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous reset, active-high
//   r0_valid    in   requester 0 has an operation
//   r0_ready    out  requester 0 operation accepted this cycle (IDLE only)
//   r0_op       in   2'b00 CLZ, 2'b01 CTZ, 2'b10 CPOP, 2'b11 reserved
//   r0_data     in   operand (rs1)
//   r1_*        as r0_*, for requester 1
//   rsp_valid   out  result available (DONE state)
//   rsp_ready   in   consumer takes result
//   rsp_id      out  requester index of the result
//   rsp_data    out  zero-extended count
//   busy        out  engine is not IDLE
// -----------------------------------------------------------------------------
module zbb_count_seq #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic [1:0]      r0_op,
  input  logic [XLEN-1:0] r0_data,
  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic [1:0]      r1_op,
  input  logic [XLEN-1:0] r1_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_data,
  output logic            busy
);

  localparam int BEATS  = XLEN / CHUNK;
  localparam int CNT_W  = $clog2(XLEN) + 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] OP_CLZ  = 2'b00;
  localparam logic [1:0] OP_CTZ  = 2'b01;
  localparam logic [1:0] OP_CPOP = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] f_bitrev(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = '0;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] f_popcount(input logic [CHUNK-1:0] c);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < CHUNK; i++) begin
      n = n + CNT_W'(c[i]);
    end
    return n;
  endfunction

  // Trailing zeros of one chunk; an all-zero chunk counts as CHUNK. Scanning
  // from the top down lets the lowest set bit win.
  function automatic logic [CNT_W-1:0] f_trailing_zeros(input logic [CHUNK-1:0] c);
    logic [CNT_W-1:0] n;
    n = CNT_W'(CHUNK);
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (c[i]) begin
        n = CNT_W'(i);
      end
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic [1:0]        r_op;
  logic              r_id;
  logic [XLEN-1:0]   r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_found;
  logic [BEAT_W-1:0] r_beat;
  logic              r_last_grant;

  state_t            w_state_nxt;
  logic [1:0]        w_op_nxt;
  logic              w_id_nxt;
  logic [XLEN-1:0]   w_shift_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_found_nxt;
  logic [BEAT_W-1:0] w_beat_nxt;
  logic              w_last_grant_nxt;

  // ---------------------------------------------------------------------------
  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  // ---------------------------------------------------------------------------
  logic            w_gnt_valid;
  logic            w_gnt_id;
  logic [1:0]      w_gnt_op;
  logic [XLEN-1:0] w_gnt_data;
  logic            w_accept;

  assign w_gnt_valid = r0_valid | r1_valid;
  assign w_gnt_id    = (r0_valid && r1_valid) ? ~r_last_grant : r1_valid;
  assign w_gnt_op    = w_gnt_id ? r1_op   : r0_op;
  assign w_gnt_data  = w_gnt_id ? r1_data : r0_data;
  assign w_accept    = (r_state == S_IDLE) && w_gnt_valid;

  // ---------------------------------------------------------------------------
  // Per-beat scan of the low chunk of the shift register
  // ---------------------------------------------------------------------------
  logic [CHUNK-1:0] w_chunk;
  logic             w_chunk_nz;
  logic [CNT_W-1:0] w_chunk_pop;
  logic [CNT_W-1:0] w_chunk_tz;
  logic             w_last_beat;
  logic             w_is_cpop;

  assign w_chunk     = r_shift[CHUNK-1:0];
  assign w_chunk_nz  = |w_chunk;
  assign w_chunk_pop = f_popcount(w_chunk);
  assign w_chunk_tz  = f_trailing_zeros(w_chunk);
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_is_cpop   = (r_op == OP_CPOP);

  // ---------------------------------------------------------------------------
  // Process 1: state register and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  // NOTE: every register, including the operand shift register, is reset so
  // the outputs come out of reset with defined values (rsp_data = 0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= OP_CLZ;
      r_id         <= 1'b0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_found      <= 1'b0;
      r_beat       <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_op         <= w_op_nxt;
      r_id         <= w_id_nxt;
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_found      <= w_found_nxt;
      r_beat       <= w_beat_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state and next-datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a hold default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_op_nxt         = r_op;
    w_id_nxt         = r_id;
    w_shift_nxt      = r_shift;
    w_cnt_nxt        = r_cnt;
    w_found_nxt      = r_found;
    w_beat_nxt       = r_beat;
    w_last_grant_nxt = r_last_grant;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_op_nxt         = w_gnt_op;
          w_id_nxt         = w_gnt_id;
          w_shift_nxt      = (w_gnt_op == OP_CLZ) ? f_bitrev(w_gnt_data) : w_gnt_data;
          w_cnt_nxt        = '0;
          w_found_nxt      = 1'b0;
          w_beat_nxt       = '0;
          w_last_grant_nxt = w_gnt_id;
          // Reserved op returns zero without scanning.
          w_state_nxt      = (w_gnt_op == OP_RSVD) ? S_DONE : S_RUN;
        end
      end

      S_RUN: begin
        w_shift_nxt = r_shift >> CHUNK;
        if (w_is_cpop) begin
          w_cnt_nxt = r_cnt + w_chunk_pop;
          if (w_last_beat) begin
            w_state_nxt = S_DONE;
          end else begin
            w_beat_nxt = r_beat + BEAT_W'(1);
          end
        end else begin
          // CLZ/CTZ: accumulate whole zero chunks until the first set bit,
          // then stop early. A zero operand sums to XLEN without wrapping
          // because the counter is one bit wider than log2(XLEN).
          if (!r_found) begin
            w_cnt_nxt = r_cnt + w_chunk_tz;
          end
          w_found_nxt = r_found | w_chunk_nz;
          if (w_chunk_nz || w_last_beat) begin
            w_state_nxt = S_DONE;
          end else begin
            w_beat_nxt = r_beat + BEAT_W'(1);
          end
        end
      end

      S_DONE: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    r0_ready  = 1'b0;
    r1_ready  = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;

    // Ready is a pure function of state and the arbiter; it is also masked
    // while reset is held so no requester sees an accept during reset.
    if (w_accept && !rst) begin
      r0_ready = ~w_gnt_id;
      r1_ready =  w_gnt_id;
    end

    rsp_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
  end

  assign rsp_id   = r_id;
  assign rsp_data = {{(XLEN - CNT_W){1'b0}}, r_cnt};

endmodule

// File: tb/tb_zbb_count_seq.sv
// -----------------------------------------------------------------------------
// tb_zbb_count_seq
//   Self-checking bench for zbb_count_seq. Each accepted request pushes its
//   expected id, result and first-valid cycle into a scoreboard queue. A
//   negedge monitor checks response latency on the first valid cycle and
//   pops/compares on every handshake.
// -----------------------------------------------------------------------------
module tb_zbb_count_seq;

  localparam int XLEN  = 32;
  localparam int CHUNK = 8;
  localparam int BEATS = XLEN / CHUNK;

  localparam logic [1:0] OP_CLZ  = 2'b00;
  localparam logic [1:0] OP_CTZ  = 2'b01;
  localparam logic [1:0] OP_CPOP = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  logic            clk;
  logic            rst;
  logic            r0_valid, r0_ready;
  logic [1:0]      r0_op;
  logic [XLEN-1:0] r0_data;
  logic            r1_valid, r1_ready;
  logic [1:0]      r1_op;
  logic [XLEN-1:0] r1_data;
  logic            rsp_valid, rsp_ready, rsp_id, busy;
  logic [XLEN-1:0] rsp_data;

  zbb_count_seq #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .r0_valid  (r0_valid),
    .r0_ready  (r0_ready),
    .r0_op     (r0_op),
    .r0_data   (r0_data),
    .r1_valid  (r1_valid),
    .r1_ready  (r1_ready),
    .r1_op     (r1_op),
    .r1_data   (r1_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic            id;
    logic [XLEN-1:0] data;
    int              cyc;
  } exp_t;

  exp_t exp_q[$];
  logic grant_q[$];

  task automatic check(input string tag, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: straightforward whole-word counts plus beat count.
  // ---------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] model_result(input logic [1:0] op,
                                                   input logic [XLEN-1:0] d);
    int n;
    n = 0;
    case (op)
      OP_CLZ: begin
        n = XLEN;
        for (int i = 0; i < XLEN; i++) if (d[i]) n = XLEN - 1 - i;
      end
      OP_CTZ: begin
        n = XLEN;
        for (int i = XLEN - 1; i >= 0; i--) if (d[i]) n = i;
      end
      OP_CPOP: begin
        for (int i = 0; i < XLEN; i++) n += int'(d[i]);
      end
      default: n = 0;
    endcase
    return XLEN'(n);
  endfunction

  function automatic int model_beats(input logic [1:0] op, input logic [XLEN-1:0] d);
    int pos;
    if (op == OP_CPOP) return BEATS;
    if (op == OP_RSVD) return 0;
    pos = -1;
    // Position (from the scan start) of the first set bit.
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (op == OP_CTZ && d[i]) pos = i;
      if (op == OP_CLZ && d[XLEN-1-i]) pos = i;
    end
    if (pos < 0) return BEATS;
    return pos / CHUNK + 1;
  endfunction

  // ---------------------------------------------------------------------------
  // Requester driver: hold valid until ready, then score the expected result.
  // ---------------------------------------------------------------------------
  task automatic issue(input logic id, input logic [1:0] op, input logic [XLEN-1:0] d);
    exp_t e;
    logic got;
    if (!id) begin r0_valid = 1'b1; r0_op = op; r0_data = d; end
    else     begin r1_valid = 1'b1; r1_op = op; r1_data = d; end
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if ((!id && r0_ready) || (id && r1_ready)) got = 1'b1;
    end
    check($sformatf("accept_r%0d", id), XLEN'(got), XLEN'(1));
    if (got) begin
      e.id   = id;
      e.data = model_result(op, d);
      e.cyc  = cyc + 1 + model_beats(op, d);
      exp_q.push_back(e);
      grant_q.push_back(id);
    end
    @(posedge clk);
    #1;
    if (!id) r0_valid = 1'b0;
    else     r1_valid = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    check("drain", XLEN'(done), XLEN'(1));
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Response monitor
  // ---------------------------------------------------------------------------
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (rsp_valid && !prev_v) begin
        if (exp_q.size() == 0) check("spurious_rsp", XLEN'(rsp_valid), XLEN'(0));
        else                   check("latency", XLEN'(cyc), XLEN'(exp_q[0].cyc));
      end
      if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rsp_id", XLEN'(rsp_id), XLEN'(e.id));
        check("rsp_data", rsp_data, e.data);
      end
      prev_v = rsp_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0]      rop;
    logic [XLEN-1:0] rdat;
    logic            rid;

    rst = 1'b1;
    r0_valid = 1'b0; r0_op = '0; r0_data = '0;
    r1_valid = 1'b0; r1_op = '0; r1_data = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", XLEN'(rsp_valid), '0);
    check("rst_rsp_id",    XLEN'(rsp_id),    '0);
    check("rst_rsp_data",  rsp_data,         '0);
    check("rst_busy",      XLEN'(busy),      '0);
    check("rst_r0_ready",  XLEN'(r0_ready),  '0);
    check("rst_r1_ready",  XLEN'(r1_ready),  '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Round-robin: both valid after reset; r0 then re-requests.
    grant_q.delete();
    fork
      begin
        issue(1'b0, OP_CPOP, 32'hF0F0_0001);
        issue(1'b0, OP_CLZ,  32'h0001_0000);
      end
      issue(1'b1, OP_CTZ, 32'h0000_0100);
    join
    drain();
    check("rr_count", XLEN'(grant_q.size()), XLEN'(3));
    if (grant_q.size() == 3) begin
      check("rr_grant0", XLEN'(grant_q[0]), XLEN'(0));
      check("rr_grant1", XLEN'(grant_q[1]), XLEN'(1));
      check("rr_grant2", XLEN'(grant_q[2]), XLEN'(0));
    end

    // Directed single operations.
    issue(1'b0, OP_CPOP, 32'hF0F0_0001); drain();
    issue(1'b1, OP_CTZ,  32'h0000_0100); drain();
    issue(1'b1, OP_CLZ,  32'h8000_0000); drain();
    issue(1'b0, OP_CLZ,  32'h0000_0000); drain();
    issue(1'b0, OP_CTZ,  32'h0000_0000); drain();
    issue(1'b1, OP_RSVD, 32'h1234_5678); drain();
    issue(1'b0, OP_CLZ,  32'h0000_0001); drain();
    issue(1'b1, OP_CTZ,  32'h8000_0000); drain();
    issue(1'b0, OP_CPOP, 32'hFFFF_FFFF); drain();

    // Random operations, sparse operands to exercise early exit.
    for (int i = 0; i < 16; i++) begin
      rop  = 2'($urandom_range(0, 3));
      rid  = 1'($urandom_range(0, 1));
      rdat = $urandom() & ($urandom() >> $urandom_range(0, 31));
      issue(rid, rop, rdat);
      drain();
    end

    // Back-pressure: hold rsp_ready low for 3 cycles with r1 waiting.
    rsp_ready = 1'b0;
    issue(1'b0, OP_CTZ, 32'h0001_0000);
    fork
      issue(1'b1, OP_CPOP, 32'h0000_0003);
      begin
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
          @(negedge clk);
          if (rsp_valid) seen = 1'b1;
        end
        check("stall_valid_seen", XLEN'(seen), XLEN'(1));
        for (int k = 0; k < 3; k++) begin
          if (k > 0) @(negedge clk);
          check("stall_rsp_valid", XLEN'(rsp_valid), XLEN'(1));
          check("stall_rsp_data",  rsp_data, (exp_q.size() > 0) ? exp_q[0].data : '1);
          check("stall_rsp_id",    XLEN'(rsp_id),    XLEN'(0));
          check("stall_r0_ready",  XLEN'(r0_ready),  XLEN'(0));
          check("stall_r1_ready",  XLEN'(r1_ready),  XLEN'(0));
          check("stall_busy",      XLEN'(busy),      XLEN'(1));
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a CPOP scan: no response, then a clean op.
    issue(1'b0, OP_CPOP, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check("pre_rst_busy", XLEN'(busy), XLEN'(1));
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", XLEN'(rsp_valid), '0);
    check("midrst_busy",      XLEN'(busy),      '0);
    check("midrst_r0_ready",  XLEN'(r0_ready),  '0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_no_rsp", XLEN'(rsp_valid), '0);
    end
    @(posedge clk);
    #1;
    issue(1'b1, OP_CPOP, 32'h0000_000F);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
